uart_tx_arbiter: RTL and testbench

Shares one UART byte transmitter among N requesters with round-robin arbitration and packet locking. Each requester offers bytes on a valid/ready handshake. The arbiter latches the granted byte, launches the transmitter, and waits for frame completion and an inter-frame gap before re-arbitrating. It sits between the on-chip byte producers and the single UART TX datapath.

---
 rtl/uart_arb_pkg.sv | 21 ++
 rtl/uart_tx_arbiter_rr_pick.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and sizing helpers for the UART TX arbiter.
package uart_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACCEPT,
        START,
        WAIT_BUSY,
        WAIT_DONE,
        GAP
    } arb_state_e;

    localparam int N_DEFAULT = 4;
    localparam int ID_W      = $clog2(N_DEFAULT);

    // Width of a counter that must hold values 0..max_count.
    function automatic int cnt_width(input int max_count);
        return (max_count < 2) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Rotating-priority picker: first asserted request at or after ptr, wrapping at N-1.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int N  = N_DEFAULT,
    parameter int IW = ID_W
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          any,
    output logic [IW-1:0] idx
);

    int            c;
    logic [IW-1:0] cidx;

    // Scan from the farthest offset down so the nearest match is written last.
    always_comb begin
        any  = |req;
        idx  = '0;
        c    = 0;
        cidx = '0;
        for (int off = N - 1; off >= 0; off--) begin
            c = int'(ptr) + off;
            if (c >= N) c = c - N;
            cidx = IW'(c);
            if (req[cidx]) idx = cidx;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter among N requesters,
// with packet locking, start-timeout detection and an inter-frame gap.
//
// state     | meaning
// IDLE      | pick a requester (or wait for the locked one)
// ACCEPT    | req_ready to grantee; latch its byte if still valid
// START     | one-cycle tx_start pulse, arm the start timer
// WAIT_BUSY | wait for tx_busy to rise, abort on timer expiry
// WAIT_DONE | frame in progress, tx_data held
// GAP       | idle spacing before re-arbitration
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N             = 4,
    parameter int GAP_CYCLES    = 2,
    parameter int START_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req_valid,
    input  logic [8*N-1:0]       req_data,
    input  logic [N-1:0]         req_last,
    output logic [N-1:0]         req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_start,
    input  logic                 tx_busy,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 active,
    output logic                 lock,
    output logic                 err_timeout,
    input  logic                 err_clr
);

    localparam int IDW = $clog2(N);
    localparam int TW  = cnt_width(START_TIMEOUT);
    localparam int GW  = cnt_width(GAP_CYCLES);

    arb_state_e     state_q, state_d;
    logic [IDW-1:0] grant_id_q, grant_id_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [7:0]     tx_data_q, tx_data_d;
    logic           last_q, last_d;
    logic           active_q, active_d;
    logic           lock_q, lock_d;
    logic           err_q, err_d;
    logic           tx_start_q, tx_start_d;
    logic [TW-1:0]  tmr_q, tmr_d;
    logic [GW-1:0]  gap_q, gap_d;

    logic           pick_any;
    logic [IDW-1:0] pick_idx;
    logic [7:0]     sel_byte;
    logic [IDW-1:0] next_ptr;
    logic           timeout_evt;
    logic           gap_exit;

    rr_pick #(
        .N  (N),
        .IW (IDW)
    ) u_pick (
        .req (req_valid),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_comb begin
        sel_byte = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_id_q == IDW'(i)) sel_byte = req_data[8*i +: 8];
        end
    end

    assign next_ptr = (grant_id_q == IDW'(N - 1)) ? '0 : grant_id_q + IDW'(1);

    always_comb begin
        state_d     = state_q;
        grant_id_d  = grant_id_q;
        ptr_d       = ptr_q;
        tx_data_d   = tx_data_q;
        last_d      = last_q;
        active_d    = active_q;
        lock_d      = lock_q;
        tmr_d       = tmr_q;
        gap_d       = gap_q;
        tx_start_d  = 1'b0;
        timeout_evt = 1'b0;
        gap_exit    = 1'b0;

        case (state_q)
            IDLE: begin
                if (lock_q) begin
                    if (req_valid[grant_id_q]) state_d = ACCEPT;
                end else if (pick_any) begin
                    grant_id_d = pick_idx;
                    state_d    = ACCEPT;
                end
            end
            ACCEPT: begin
                if (req_valid[grant_id_q]) begin
                    tx_data_d  = sel_byte;
                    last_d     = req_last[grant_id_q];
                    active_d   = 1'b1;
                    tx_start_d = 1'b1;
                    state_d    = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                // Down-counter expires exactly START_TIMEOUT cycles after tx_start.
                tmr_d   = TW'(START_TIMEOUT - 1);
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (tmr_q <= TW'(1)) begin
                    timeout_evt = 1'b1;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    if (GAP_CYCLES == 0) begin
                        gap_exit = 1'b1;
                    end else begin
                        gap_d   = GW'(GAP_CYCLES);
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_q <= GW'(1)) gap_exit = 1'b1;
                else                 gap_d = gap_q - GW'(1);
            end
            default: state_d = IDLE;
        endcase

        if (gap_exit) begin
            state_d  = IDLE;
            active_d = 1'b0;
            if (last_q) begin
                lock_d = 1'b0;
                ptr_d  = next_ptr;
            end else begin
                lock_d = 1'b1;
            end
        end

        // Abandoned byte: release the grantee and move on.
        if (timeout_evt) begin
            state_d  = IDLE;
            active_d = 1'b0;
            lock_d   = 1'b0;
            ptr_d    = next_ptr;
        end

        err_d = (err_q & ~err_clr) | timeout_evt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            grant_id_q <= '0;
            ptr_q      <= '0;
            tx_data_q  <= '0;
            last_q     <= 1'b0;
            active_q   <= 1'b0;
            lock_q     <= 1'b0;
            err_q      <= 1'b0;
            tx_start_q <= 1'b0;
            tmr_q      <= '0;
            gap_q      <= '0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            ptr_q      <= ptr_d;
            tx_data_q  <= tx_data_d;
            last_q     <= last_d;
            active_q   <= active_d;
            lock_q     <= lock_d;
            err_q      <= err_d;
            tx_start_q <= tx_start_d;
            tmr_q      <= tmr_d;
            gap_q      <= gap_d;
        end
    end

    assign req_ready   = (state_q == ACCEPT) ? (N'(1) << grant_id_q) : '0;
    assign tx_data     = tx_data_q;
    assign tx_start    = tx_start_q;
    assign grant_id    = grant_id_q;
    assign active      = active_q;
    assign lock        = lock_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester/transmitter models drive traffic,
// a monitor checks every tx_start against the expected grant queue.
module tb_uart_tx_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_last = '0;
    logic [N-1:0]   req_ready;
    logic [7:0]     tx_data;
    logic           tx_start;
    logic           tx_busy = 1'b0;
    logic [1:0]     grant_id;
    logic           active;
    logic           lock;
    logic           err_timeout;
    logic           err_clr = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    logic [10:0] exp_q[$];      // {lock, grant_id, data}
    logic [8:0]  rq[N][$];      // {last, data}
    logic [N-1:0] consumed = '0;
    logic [N-1:0] abort_f  = '0;
    int  busy_len = 11;
    bit  busy_en  = 1'b1;
    int  cyc = 0, last_start = 0, prev_start = 0, n_starts = 0, ready_pulses = 0;

    uart_tx_arbiter #(
        .N             (N),
        .GAP_CYCLES    (2),
        .START_TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_busy     (tx_busy),
        .grant_id    (grant_id),
        .active      (active),
        .lock        (lock),
        .err_timeout (err_timeout),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic push(input int id, input logic [7:0] d, input bit last);
        rq[id].push_back({last, d});
    endtask

    task automatic exp_push(input int id, input logic [7:0] d, input bit lk);
        exp_q.push_back({lk, 2'(id), d});
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_tx_start"}, tx_start, 0);
        chk({tag, "_tx_data"}, tx_data, 0);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_grant_id"}, grant_id, 0);
        chk({tag, "_active"}, active, 0);
        chk({tag, "_lock"}, lock, 0);
        chk({tag, "_err_timeout"}, err_timeout, 0);
    endtask

    task automatic wait_start(input string name);
        int k = 0;
        while (!tx_start && k < 300) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (k >= 300) begin
            n_bad++;
            $display("FAIL %s: no tx_start within %0d cycles", name, k);
        end
    endtask

    task automatic wait_idle(input string name);
        int  k = 0;
        bit  done = 1'b0;
        while (!done && k < 600) begin
            @(negedge clk);
            k++;
            done = (exp_q.size() == 0) && !active && !tx_busy;
            for (int i = 0; i < N; i++) if (rq[i].size() != 0) done = 1'b0;
        end
        n_cmp++;
        if (!done) begin
            n_bad++;
            $display("FAIL %s: traffic not drained after %0d cycles, %0d expected left", name, k, exp_q.size());
        end
    endtask

    // Requesters: hold front entry valid, pop it once the accept edge has passed.
    initial begin
        logic [8:0] ent;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (consumed[i]) begin
                    if (rq[i].size() > 0) void'(rq[i].pop_front());
                    consumed[i] = 1'b0;
                end
                if (rq[i].size() > 0) begin
                    ent = rq[i][0];
                    req_valid[i]       = 1'b1;
                    req_data[8*i +: 8] = ent[7:0];
                    req_last[i]        = ent[8];
                end else begin
                    req_valid[i] = 1'b0;
                end
                if (req_ready[i] && req_valid[i]) begin
                    if (abort_f[i]) begin
                        req_valid[i] = 1'b0;
                        rq[i].delete();
                        abort_f[i]   = 1'b0;
                    end else begin
                        consumed[i] = 1'b1;
                    end
                end
            end
        end
    end

    // Transmitter: busy rises one cycle after tx_start and lasts busy_len cycles.
    initial begin
        int cnt  = 0;
        bit pend = 1'b0;
        forever begin
            @(negedge clk);
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) tx_busy = 1'b0;
            end else if (pend) begin
                pend    = 1'b0;
                tx_busy = 1'b1;
                cnt     = busy_len;
            end
            if (tx_start && busy_en) pend = 1'b1;
        end
    end

    // Monitor / scoreboard.
    initial begin
        logic [10:0] e;
        logic [7:0]  held = '0;
        bit          have = 1'b0;
        bit          act_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (req_ready != '0) begin
                ready_pulses++;
                chk("ready_onehot", $countones(req_ready), 1);
                chk("ready_is_grantee", int'(req_ready[grant_id]), 1);
            end
            if (tx_start) begin
                n_starts++;
                prev_start = last_start;
                last_start = cyc;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_tx_start: grant %0d data 0x%0h, nothing expected", grant_id, tx_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("grant_id", grant_id, e[9:8]);
                    chk("tx_data", tx_data, e[7:0]);
                    chk("lock_at_start", lock, e[10]);
                end
                held = tx_data;
                have = 1'b1;
            end else if (act_prev && !active && rst && have) begin
                chk("tx_data_held", tx_data, held);
            end
            act_prev = active;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int rp0;
        int s0;

        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outs("reset");
        rst = 1'b1;
        @(negedge clk);

        // All four valid, last=1: plain rotation from pointer 0.
        push(0, 8'h40, 1); push(1, 8'h41, 1); push(2, 8'h42, 1); push(3, 8'h43, 1); push(0, 8'h44, 1);
        exp_push(0, 8'h40, 0); exp_push(1, 8'h41, 0); exp_push(2, 8'h42, 0);
        exp_push(3, 8'h43, 0); exp_push(0, 8'h44, 0);
        wait_idle("rr_all");
        chk("rr_frame_spacing", last_start - prev_start, 17);

        // Single requester 2, 0xA5, busy 11 cycles.
        rp0 = ready_pulses;
        push(2, 8'hA5, 1);
        exp_push(2, 8'hA5, 0);
        wait_start("single_start");
        cnt = 0;
        while (active && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        chk("single_active_cycles", cnt, 15);
        wait_idle("single");
        chk("single_ready_pulses", ready_pulses - rp0, 1);
        chk("single_lock", lock, 0);
        chk("single_grant_id", grant_id, 2);

        // Pointer now 3: 3 must beat 0.
        push(0, 8'h10, 1); push(3, 8'h13, 1);
        exp_push(3, 8'h13, 0); exp_push(0, 8'h10, 0);
        wait_idle("ptr_after_single");

        // Locked 3-byte packet from requester 1 while requester 0 keeps asking.
        push(1, 8'h51, 0); push(1, 8'h52, 0); push(1, 8'h53, 1);
        push(0, 8'h60, 1); push(0, 8'h61, 1);
        exp_push(1, 8'h51, 0); exp_push(1, 8'h52, 1); exp_push(1, 8'h53, 1);
        exp_push(0, 8'h60, 0); exp_push(0, 8'h61, 0);
        wait_idle("packet_lock");
        chk("packet_lock_released", lock, 0);

        // Start timeout: requester 1 never sees busy, requester 2 served next.
        busy_en = 1'b0;
        push(1, 8'h3C, 1); push(2, 8'h7E, 1);
        exp_push(1, 8'h3C, 0); exp_push(2, 8'h7E, 0);
        wait_start("timeout_start");
        cnt = 0;
        while (!err_timeout && cnt < 60) begin
            @(negedge clk);
            cnt++;
        end
        chk("timeout_latency", cnt, 16);
        chk("timeout_active_dropped", active, 0);
        busy_en = 1'b1;
        wait_idle("timeout_next");
        chk("timeout_err_sticky", err_timeout, 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("timeout_err_cleared", err_timeout, 0);

        // Requester 3 withdraws in its ACCEPT cycle; pointer must stay at 3.
        s0 = n_starts;
        abort_f[3] = 1'b1;
        push(3, 8'h11, 1);
        cnt = 0;
        while (abort_f[3] && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        chk("drop_seen_accept", int'(abort_f[3]), 0);
        repeat (10) @(negedge clk);
        chk("drop_no_tx_start", n_starts - s0, 0);
        chk("drop_active", active, 0);
        push(0, 8'h22, 1); push(3, 8'h33, 1);
        exp_push(3, 8'h33, 0); exp_push(0, 8'h22, 0);
        wait_idle("drop_ptr_kept");

        // Reset in WAIT_DONE, then arbitration restarts from requester 0.
        push(1, 8'h5A, 1);
        exp_push(1, 8'h5A, 0);
        wait_start("rst_mid_start");
        repeat (4) @(negedge clk);
        chk("rst_mid_active_before", active, 1);
        rst = 1'b0;
        #1;
        chk_reset_outs("rst_mid");
        cnt = 0;
        while (tx_busy && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        @(negedge clk);
        rst = 1'b1;
        push(2, 8'h77, 1); push(0, 8'h66, 1);
        exp_push(0, 8'h66, 0); exp_push(2, 8'h77, 0);
        wait_idle("rst_restart");

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
